// File: rtl/result_drain.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | result_drain: captures a finished accumulator tile and streams each element |
// | row-major as a shifted, saturated OUT_WIDTH value over valid/ready.         |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module result_drain #(
   parameter int WIDTH      = 8,
   parameter int ARRAY_SIZE = 4,
   parameter int ACC_WIDTH  = 2*WIDTH+2,
   parameter int OUT_WIDTH  = 8,
   parameter int IDX_WIDTH  = $clog2(ARRAY_SIZE*ARRAY_SIZE)
) (
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic                                      res_valid,
   input  logic [ACC_WIDTH*ARRAY_SIZE*ARRAY_SIZE-1:0] result,
   input  logic [4:0]                                shift,
   output logic                                      busy,
   output logic                                      m_valid,
   input  logic                                      m_ready,
   output logic [OUT_WIDTH-1:0]                      m_data,
   output logic [IDX_WIDTH-1:0]                      m_index,
   output logic                                      m_last,
   output logic                                      m_sat,
   output logic                                      drop_err
);

   localparam int                     c_NELEM    = ARRAY_SIZE*ARRAY_SIZE;
   localparam logic [4:0]             c_MAX_SH   = 5'(ACC_WIDTH-1);
   localparam logic [IDX_WIDTH-1:0]   c_LAST_IDX = IDX_WIDTH'(c_NELEM-1);
   localparam logic signed [ACC_WIDTH-1:0] c_POS_LIM = ACC_WIDTH'((2**(OUT_WIDTH-1))-1);
   localparam logic signed [ACC_WIDTH-1:0] c_NEG_LIM = ACC_WIDTH'(-(2**(OUT_WIDTH-1)));

   typedef enum logic [0:0] {
      S_IDLE   = 1'b0,
      S_STREAM = 1'b1
   } state_t;

   state_t                                     r_state;
   logic [ACC_WIDTH*c_NELEM-1:0]               r_cap;
   logic [4:0]                                 r_shift;
   logic [IDX_WIDTH-1:0]                       r_idx;
   logic                                       r_drop;

   logic signed [ACC_WIDTH-1:0]                w_elems [c_NELEM];
   logic signed [ACC_WIDTH-1:0]                w_elem;
   logic signed [ACC_WIDTH-1:0]                w_y;
   logic [4:0]                                 w_sh;
   logic [OUT_WIDTH-1:0]                       w_data;
   logic                                       w_sat;
   logic                                       w_busy;
   logic                                       w_last;

   generate
      for (genvar k = 0; k < c_NELEM; k++) begin : g_unpack
         assign w_elems[k] = r_cap[k*ACC_WIDTH +: ACC_WIDTH];
      end
   endgenerate

   // Shifts beyond ACC_WIDTH-1 behave like a full sign-fill.
   assign w_elem = w_elems[r_idx];
   assign w_sh   = (r_shift > c_MAX_SH) ? c_MAX_SH : r_shift;
   assign w_y    = w_elem >>> w_sh;

   always_comb begin
      w_data = w_y[OUT_WIDTH-1:0];
      w_sat  = 1'b0;
      if (w_y > c_POS_LIM) begin
         w_data = {1'b0, {(OUT_WIDTH-1){1'b1}}};
         w_sat  = 1'b1;
      end else if (w_y < c_NEG_LIM) begin
         w_data = {1'b1, {(OUT_WIDTH-1){1'b0}}};
         w_sat  = 1'b1;
      end
   end

   assign w_busy = (r_state == S_STREAM);
   assign w_last = (r_idx == c_LAST_IDX);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_cap   <= '0;
         r_shift <= '0;
         r_idx   <= '0;
         r_drop  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (res_valid) begin
                  r_cap   <= result;
                  r_shift <= shift;
                  r_idx   <= '0;
                  r_state <= S_STREAM;
               end
            end
            S_STREAM: begin
               // A new tile cannot be accepted until the current one is drained.
               if (res_valid) begin
                  r_drop <= 1'b1;
               end
               if (m_ready) begin
                  if (w_last) begin
                     r_idx   <= '0;
                     r_state <= S_IDLE;
                  end else begin
                     r_idx <= r_idx + 1'b1;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign busy     = w_busy;
   assign m_valid  = w_busy;
   assign m_data   = w_busy ? w_data : '0;
   assign m_sat    = w_busy & w_sat;
   assign m_last   = w_busy & w_last;
   assign m_index  = r_idx;
   assign drop_err = r_drop;

endmodule
`default_nettype wire
